// File: rtl/spram_rr_arbiter_if.sv
// Requester-side bundle for spram_rr_arbiter: one access request channel plus its read-response return.
// An access transfers in a cycle where valid && ready; valid, we, addr and wdata stay stable until then; resp_valid is a one-cycle pulse with no backpressure.
interface spram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 7
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, resp_valid, resp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/spram_rr_arbiter.sv
// Round-robin sharing of one single-port RAM between two requesters, with read data routed back after LATENCY cycles.
// Define SPRAM_ARB_INIT_EN to zero-fill the whole RAM after reset before any request is accepted.
module spram_rr_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 128,
  parameter  int LATENCY    = 1,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  spram_rr_arbiter_if.slave     req0,
  spram_rr_arbiter_if.slave     req1,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_init_busy,
  output logic                  o_dbg_state
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last;
  logic                 w_run;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_sweep_done;
  logic [ADDR_W-1:0]    w_sweep_addr;
  logic [LATENCY-1:0]   r_pend0;
  logic [LATENCY-1:0]   r_pend1;

`ifdef SPRAM_ARB_INIT_EN
  localparam state_t          RST_STATE    = ST_INIT;
  localparam int unsigned     SWEEP_LAST_I = DEPTH - 1;
  localparam logic [ADDR_W:0] SWEEP_LAST   = SWEEP_LAST_I[ADDR_W:0];

  logic [ADDR_W:0] r_sweep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_sweep <= '0;
    else if (r_state == ST_INIT) r_sweep <= r_sweep + 1'b1;
  end

  assign w_sweep_done = (r_sweep == SWEEP_LAST);
  assign w_sweep_addr = r_sweep[ADDR_W-1:0];
  assign o_init_busy  = (r_state == ST_INIT);
`else
  localparam state_t RST_STATE = ST_RUN;

  assign w_sweep_done = 1'b1;
  assign w_sweep_addr = '0;
  assign o_init_busy  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && w_sweep_done) w_state_nxt = ST_RUN;
  end

  // Grants are forced off while rst is held so outputs sit at their reset values.
  assign w_run  = (r_state == ST_RUN) && !rst;
  assign w_gnt0 = w_run && req0.valid && (!req1.valid || r_last);
  assign w_gnt1 = w_run && req1.valid && (!req0.valid || !r_last);

  // Output logic
  always_comb begin
    o_ram_en   = 1'b0;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    req0.ready = w_gnt0;
    req1.ready = w_gnt1;
    if (r_state == ST_INIT && !rst) begin
      o_ram_en   = 1'b1;
      o_ram_we   = 1'b1;
      o_ram_addr = w_sweep_addr;
    end else if (w_gnt0) begin
      o_ram_en   = 1'b1;
      o_ram_we   = req0.we;
      o_ram_addr = req0.addr;
      o_ram_din  = req0.wdata;
    end else if (w_gnt1) begin
      o_ram_en   = 1'b1;
      o_ram_we   = req1.we;
      o_ram_addr = req1.addr;
      o_ram_din  = req1.wdata;
    end
  end

  // r_last remembers which port took the most recent grant; 1 after reset so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_last <= 1'b1;
    else if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
  end

  // One marker per accepted read travels LATENCY stages alongside the RAM pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend0 <= '0;
      r_pend1 <= '0;
    end else begin
      r_pend0 <= LATENCY'({r_pend0, w_gnt0 && !req0.we});
      r_pend1 <= LATENCY'({r_pend1, w_gnt1 && !req1.we});
    end
  end

  assign req0.resp_valid = r_pend0[LATENCY-1];
  assign req1.resp_valid = r_pend1[LATENCY-1];
  assign req0.resp_rdata = i_ram_dout;
  assign req1.resp_rdata = i_ram_dout;
  assign o_dbg_state     = r_state;

endmodule
